// File: rtl/btn_conditioner.sv
// Purpose : synchronise, debounce and edge-detect four push buttons (up/next/set/stop).
// Latency : press pulse DEBOUNCE_CYCLES+2 edges after the first edge that samples raw=1.
// Backpressure: none; pulses are one-cycle strobes that the consumer must take when they appear.
//
// Ports:
//   clk, resetTime               - clock, synchronous active-high reset
//   rawUp/rawNext/rawSet/rawStop - asynchronous bouncy button inputs
//   upTime/nextDigit/setValue/stop - one-cycle registered press pulses
//   held[3:0]                    - debounced levels {stop,set,next,up}
// Build option: define BTN_AUTO_REPEAT_EN to enable auto-repeat on the up channel.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic       clk,
  input  logic       resetTime,
  input  logic       rawUp,
  input  logic       rawNext,
  input  logic       rawSet,
  input  logic       rawStop,
  output logic       upTime,
  output logic       nextDigit,
  output logic       setValue,
  output logic       stop,
  output logic [3:0] held
);

  typedef enum logic [1:0] {
    IDLE            = 2'd0,
    CONFIRM_PRESS   = 2'd1,
    PRESSED         = 2'd2,
    CONFIRM_RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] DEB_LIMIT = 8'(DEBOUNCE_CYCLES);

  // Reject out-of-range configurations at elaboration time.
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 ||
      REPEAT_DELAY < 2 || REPEAT_DELAY > 255 ||
      REPEAT_PERIOD < 2 || REPEAT_PERIOD > 255) begin : g_bad_params
    $error("btn_conditioner: parameter out of range");
  end

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Two-flop synchronizers, one per button.
  logic [3:0] raw;
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;

  assign raw = {rawStop, rawSet, rawNext, rawUp};

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (resetTime) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  logic [3:0] pulse_vec;
  logic [3:0] held_vec;

  for (genvar i = 0; i < 4; i++) begin : g_ch
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       press_d;
    logic       rpt_fire;
    logic       pulse_q, pulse_d;
    logic       held_q, held_d;

    // The counter holds the number of agreeing samples seen so far in a
    // confirm state; the transition fires on the sample after it reaches
    // DEB_LIMIT, which gives the DEBOUNCE_CYCLES+2 edge press latency.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (sync2_q[i]) begin
            state_d = CONFIRM_PRESS;
            cnt_d   = 8'd1;
          end
        end
        CONFIRM_PRESS: begin
          if (!sync2_q[i]) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end else if (cnt_q >= DEB_LIMIT) begin
            state_d = PRESSED;
            cnt_d   = 8'd0;
            press_d = 1'b1;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        PRESSED: begin
          if (!sync2_q[i]) begin
            state_d = CONFIRM_RELEASE;
            cnt_d   = 8'd1;
          end
        end
        CONFIRM_RELEASE: begin
          // Bounce back to PRESSED is not a new press: no pulse.
          if (sync2_q[i]) begin
            state_d = PRESSED;
            cnt_d   = 8'd0;
          end else if (cnt_q >= DEB_LIMIT) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end

    assign pulse_d = press_d | rpt_fire;
    assign held_d  = (state_d == PRESSED) || (state_d == CONFIRM_RELEASE);

    always_ff @(posedge clk) begin
      if (resetTime) begin
        state_q <= IDLE;
        cnt_q   <= 8'd0;
        pulse_q <= 1'b0;
        held_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pulse_q <= pulse_d;
        held_q  <= held_d;
      end
    end

`ifdef BTN_AUTO_REPEAT_EN
    if (i == 0) begin : g_rpt
      localparam logic [7:0] RPT_DLY = 8'(REPEAT_DELAY);
      localparam logic [7:0] RPT_PER = 8'(REPEAT_PERIOD);

      logic [7:0] rpt_q, rpt_d, rpt_inc;
      logic       rep_seen_q, rep_seen_d;
      logic       fire;

      // rpt_q counts PRESSED cycles since the last pulse; it only advances
      // while staying in PRESSED, so a visit to CONFIRM_RELEASE freezes it.
      always_comb begin
        rpt_d      = rpt_q;
        rep_seen_d = rep_seen_q;
        fire       = 1'b0;
        rpt_inc    = sat_inc(rpt_q);
        if (state_q == PRESSED && state_d == PRESSED) begin
          if (rpt_inc >= (rep_seen_q ? RPT_PER : RPT_DLY)) begin
            fire       = 1'b1;
            rpt_d      = 8'd0;
            rep_seen_d = 1'b1;
          end else begin
            rpt_d = rpt_inc;
          end
        end
        if (press_d || state_d == IDLE) begin
          rpt_d      = 8'd0;
          rep_seen_d = 1'b0;
        end
      end

      assign rpt_fire = fire;

      always_ff @(posedge clk) begin
        if (resetTime) begin
          rpt_q      <= 8'd0;
          rep_seen_q <= 1'b0;
        end else begin
          rpt_q      <= rpt_d;
          rep_seen_q <= rep_seen_d;
        end
      end
    end else begin : g_no_rpt
      assign rpt_fire = 1'b0;
    end
`else
    assign rpt_fire = 1'b0;
`endif

    assign pulse_vec[i] = pulse_q;
    assign held_vec[i]  = held_q;
  end

  assign upTime    = pulse_vec[0];
  assign nextDigit = pulse_vec[1];
  assign setValue  = pulse_vec[2];
  assign stop      = pulse_vec[3];
  assign held      = held_vec;

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;

  localparam int D   = 4;
  localparam int DLY = 16;
  localparam int PER = 8;
`ifdef BTN_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk;
  logic       resetTime;
  logic       rawUp, rawNext, rawSet, rawStop;
  logic       upTime, nextDigit, setValue, stop;
  logic [3:0] held;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (DLY),
    .REPEAT_PERIOD  (PER)
  ) dut (
    .clk      (clk),
    .resetTime(resetTime),
    .rawUp    (rawUp),
    .rawNext  (rawNext),
    .rawSet   (rawSet),
    .rawStop  (rawStop),
    .upTime   (upTime),
    .nextDigit(nextDigit),
    .setValue (setValue),
    .stop     (stop),
    .held     (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: each button's synchronised value is its raw value two
  // edges earlier; the debounced level flips once D+1 consecutive synchronised
  // samples disagree with it. Up repeats are scheduled by total PRESSED time
  // since the press pulse: DLY, DLY+PER, DLY+2*PER, ...
  logic [3:0] m_s1, m_s2, lvl, exp_p;
  int         run [4];
  int         elapsed;
  int         nrep;
  int         edge_n = 0;

  int         up_q[$], nx_q[$], st_q[$], sp_q[$];
  int         held0_rise, held0_fall;
  logic       held0_prev;
  logic [3:0] held_at_set;
  bit         held3_seen;

  always @(posedge clk) begin
    logic [3:0] raw_v, samp;
    raw_v = {rawStop, rawSet, rawNext, rawUp};
    edge_n++;
    exp_p = 4'b0000;
    if (resetTime) begin
      m_s1 = 4'b0; m_s2 = 4'b0; lvl = 4'b0;
      for (int i = 0; i < 4; i++) run[i] = 0;
      elapsed = 0; nrep = 0;
    end else begin
      samp = m_s2;
      m_s2 = m_s1;
      m_s1 = raw_v;
      for (int i = 0; i < 4; i++) begin
        if (samp[i] != lvl[i]) begin
          run[i]++;
          if (run[i] == D + 1) begin
            lvl[i] = samp[i];
            run[i] = 0;
            if (samp[i]) begin
              exp_p[i] = 1'b1;
              if (i == 0) begin elapsed = 0; nrep = 0; end
            end
          end
        end else begin
          if (AR && i == 0 && lvl[0] && run[0] == 0) begin
            elapsed++;
            if (elapsed == DLY + nrep * PER) begin
              exp_p[0] = 1'b1;
              nrep++;
            end
          end
          run[i] = 0;
        end
      end
    end
    #1;
    chk("upTime",    int'(upTime),    int'(exp_p[0]));
    chk("nextDigit", int'(nextDigit), int'(exp_p[1]));
    chk("setValue",  int'(setValue),  int'(exp_p[2]));
    chk("stop",      int'(stop),      int'(exp_p[3]));
    chk("held",      int'(held),      int'(lvl));
    if (upTime)    up_q.push_back(edge_n);
    if (nextDigit) nx_q.push_back(edge_n);
    if (setValue) begin
      st_q.push_back(edge_n);
      held_at_set = held;
    end
    if (stop)      sp_q.push_back(edge_n);
    if (held[3])   held3_seen = 1'b1;
    if (held[0] && !held0_prev) held0_rise = edge_n;
    if (!held[0] && held0_prev) held0_fall = edge_n;
    held0_prev = held[0];
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    up_q.delete(); nx_q.delete(); st_q.delete(); sp_q.delete();
    held0_rise = -1; held0_fall = -1; held3_seen = 1'b0; held_at_set = 4'b0;
  endtask

  initial begin
    int e0, r0, rs, pre;
    int pat [9];
    pat = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
    held0_prev = 1'b0;
    clear_logs();
    resetTime = 1'b1;
    rawUp = 1'b0; rawNext = 1'b0; rawSet = 1'b0; rawStop = 1'b0;
    cyc(3);
    chk("reset_held", int'(held), 0);
    chk("reset_pulses", int'({stop, setValue, nextDigit, upTime}), 0);
    resetTime = 1'b0;
    cyc(3);

    // Clean up press held 40 cycles.
    clear_logs();
    e0 = edge_n + 1;
    rawUp = 1'b1;
    cyc(40);
    r0 = edge_n + 1;
    rawUp = 1'b0;
    cyc(12);
    chk("up_pulse_count", up_q.size(), AR ? 4 : 1);
    chk("up_pulse_edge", (up_q.size() > 0) ? up_q[0] : -1, e0 + 6);
    chk("held0_rise_edge", held0_rise, e0 + 6);
    chk("held0_fall_edge", held0_fall, r0 + 6);

    // Bouncing next button, settling high.
    clear_logs();
    e0 = edge_n + 1;
    for (int j = 0; j < 9; j++) begin
      rawNext = pat[j][0];
      cyc(1);
    end
    cyc(10);
    rawNext = 1'b0;
    cyc(12);
    chk("next_pulse_count", nx_q.size(), 1);
    chk("next_pulse_edge", (nx_q.size() > 0) ? nx_q[0] : -1, e0 + 11);

    // Simultaneous set and stop.
    clear_logs();
    e0 = edge_n + 1;
    rawSet = 1'b1;
    rawStop = 1'b1;
    cyc(15);
    rawSet = 1'b0;
    rawStop = 1'b0;
    cyc(12);
    chk("set_pulse_edge", (st_q.size() > 0) ? st_q[0] : -1, e0 + 6);
    chk("stop_pulse_edge", (sp_q.size() > 0) ? sp_q[0] : -1, e0 + 6);
    chk("held_at_set", int'(held_at_set), 12);

    // Reset during confirm of up, button kept high through it.
    clear_logs();
    e0 = edge_n + 1;
    rawUp = 1'b1;
    cyc(3);
    resetTime = 1'b1;
    cyc(3);
    resetTime = 1'b0;
    rs = edge_n + 1;
    cyc(15);
    rawUp = 1'b0;
    cyc(12);
    pre = 0;
    foreach (up_q[k]) if (up_q[k] < rs) pre++;
    chk("reset_abort_no_pulse", pre, 0);
    chk("after_reset_count", up_q.size(), 1);
    chk("after_reset_edge", (up_q.size() > 0) ? up_q[0] : -1, rs + 6);
    chk("reset_start_edge", rs, e0 + 6);

    // Short stop glitch.
    clear_logs();
    rawStop = 1'b1;
    cyc(3);
    rawStop = 1'b0;
    cyc(10);
    chk("glitch_stop_pulses", sp_q.size(), 0);
    chk("glitch_held3", int'(held3_seen), 0);

`ifdef BTN_AUTO_REPEAT_EN
    // Up held 60 cycles with auto-repeat.
    clear_logs();
    e0 = edge_n + 1;
    rawUp = 1'b1;
    cyc(60);
    rawUp = 1'b0;
    cyc(12);
    chk("rpt_count", up_q.size(), 6);
    chk("rpt_p0", (up_q.size() > 0) ? up_q[0] : -1, e0 + 6);
    chk("rpt_p1", (up_q.size() > 1) ? up_q[1] : -1, e0 + 22);
    chk("rpt_p2", (up_q.size() > 2) ? up_q[2] : -1, e0 + 30);
    chk("rpt_p5", (up_q.size() > 5) ? up_q[5] : -1, e0 + 54);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
